// File: rtl/qr_recombine.sv
`default_nettype none
// ============================================================================
// Module   : qr_recombine
// Purpose  : Captures one 16-beat Q/R frame, rebuilds A_hat = Q^T * R with a
//            single sequential MAC and streams it out as rounded 8-bit samples.
// Revision : 1.0 - initial release
// ============================================================================
module qr_recombine #(
    parameter int Q_DATA_WIDTH = 12,
    parameter int OUT_WIDTH    = 8,
    parameter int Q_FRAC       = 10,
    parameter int R_FRAC       = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [Q_DATA_WIDTH-1:0] in_q,
    input  logic signed [Q_DATA_WIDTH-1:0] in_r,
    output logic                           out_valid,
    output logic signed [OUT_WIDTH-1:0]    out
);

    localparam int PROD_W = 2 * Q_DATA_WIDTH;
    localparam int ACC_W  = PROD_W + 2;
    localparam int SHIFT  = Q_FRAC + R_FRAC;

    localparam logic signed [ACC_W:0] c_rnd     = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] c_sat_max = (ACC_W+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W:0] c_sat_min = -((ACC_W+1)'(1) << (OUT_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        CAL     = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [8:0]                     cnt_q, cnt_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0]    out_q, out_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [Q_DATA_WIDTH-1:0] q_mem   [16];
    logic signed [Q_DATA_WIDTH-1:0] r_mem   [16];
    logic signed [OUT_WIDTH-1:0]    res_mem [16];

    logic                           in_we;
    logic                           res_we;
    logic [1:0]                     term;
    logic [1:0]                     row_i;
    logic [1:0]                     col_j;
    logic signed [Q_DATA_WIDTH-1:0] q_sel;
    logic signed [Q_DATA_WIDTH-1:0] r_sel;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        mac;
    logic signed [ACC_W:0]          rnd_sum;
    logic signed [ACC_W:0]          rnd_shift;
    logic signed [OUT_WIDTH-1:0]    res_sat;

    // cnt in CAL = {row_i, col_j, term}; Q is read transposed (column row_i).
    assign term  = cnt_q[1:0];
    assign col_j = cnt_q[3:2];
    assign row_i = cnt_q[5:4];
    assign q_sel = q_mem[{term, row_i}];
    assign r_sel = r_mem[{term, col_j}];
    assign prod  = q_sel * r_sel;

    always_comb begin
        mac = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        if (term != 2'd0) begin
            mac = acc_q + mac;
        end
        rnd_sum   = {mac[ACC_W-1], mac} + c_rnd;
        rnd_shift = rnd_sum >>> SHIFT;
        if (rnd_shift > c_sat_max) begin
            res_sat = c_sat_max[OUT_WIDTH-1:0];
        end else if (rnd_shift < c_sat_min) begin
            res_sat = c_sat_min[OUT_WIDTH-1:0];
        end else begin
            res_sat = rnd_shift[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        in_we       = 1'b0;
        res_we      = 1'b0;
        case (state_q)
            RD_DATA: begin
                if (in_valid) begin
                    in_we = 1'b1;
                    if (cnt_q == 9'd15) begin
                        cnt_d   = 9'd0;
                        state_d = CAL;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            CAL: begin
                acc_d  = mac;
                res_we = (term == 2'd3);
                if (cnt_q == 9'd63) begin
                    cnt_d   = 9'd0;
                    state_d = OUTPUT;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            OUTPUT: begin
                if (cnt_q == 9'd16) begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    cnt_d       = 9'd0;
                    state_d     = IDLE;
                end else begin
                    out_d       = res_mem[cnt_q[3:0]];
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 9'd1;
                end
            end
            default: begin
                cnt_d   = 9'd0;
                state_d = RD_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_DATA;
            cnt_q       <= 9'd0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            if (in_we) begin
                q_mem[cnt_q[3:0]] <= in_q;
                r_mem[cnt_q[3:0]] <= in_r;
            end
            if (res_we) begin
                res_mem[cnt_q[5:2]] <= res_sat;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_qr_recombine.sv
`default_nettype none
// ============================================================================
// Module   : tb_qr_recombine
// Purpose  : Self-checking bench for qr_recombine using a vector table and an
//            expected-output queue checked against E0-relative output timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qr_recombine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_q;
    logic [11:0] in_r;
    logic        out_valid;
    logic [7:0]  out;

    qr_recombine dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_q     (in_q),
        .in_r     (in_r),
        .out_valid(out_valid),
        .out      (out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][11:0] q;
        logic [15:0][11:0] r;
        logic [15:0][7:0]  exp;
    } vec_t;

    vec_t       tbl [4];
    vec_t       rv;
    logic [7:0] sb [$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: A[i][j] = sum_k Q[k][i]*R[k][j], round half up at 2^-13, clamp.
    function automatic logic [15:0][7:0] model(input vec_t f);
        logic [15:0][7:0] res;
        for (int e = 0; e < 16; e++) begin
            longint acc = 0;
            longint rr;
            for (int k = 0; k < 4; k++) begin
                longint a = $signed(f.q[k*4 + e/4]);
                longint b = $signed(f.r[k*4 + e%4]);
                acc += a * b;
            end
            rr = (acc + 4096) >>> 13;
            if (rr > 127) rr = 127;
            if (rr < -128) rr = -128;
            res[e] = 8'(rr);
        end
        return res;
    endfunction

    // Called at a negedge; returns at the negedge just after E0.
    task automatic send_frame(input vec_t f, input int gap_at);
        for (int b = 0; b < 16; b++) sb.push_back(f.exp[b]);
        for (int b = 0; b < 16; b++) begin
            if (b == gap_at) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            in_valid = 1'b1;
            in_q     = f.q[b];
            in_r     = f.r[b];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Samples after E1..E82; leaves us at the negedge before E83.
    task automatic check_frame(input bit junk);
        logic [7:0] e;
        for (int d = 1; d <= 82; d++) begin
            bit ev;
            @(negedge clk);
            ev = (d >= 65) && (d <= 80);
            chk("out_valid_timing", int'(out_valid), int'(ev));
            if (ev) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_value", int'($signed(out)), int'($signed(e)));
                end
            end
            if (d == 81) chk("out_cleared", int'($signed(out)), 0);
            in_valid = junk && (d <= 79) && (d % 6 == 0);
            in_q     = 12'($urandom);
            in_r     = 12'($urandom);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int exp_id  [16] = '{10, 1, -2, 0, 0, 3, 0, 0, 0, 0, -1, 0, 0, 0, 0, 127};
        int exp_pm  [16] = '{0, 3, 0, 0, 10, 1, -2, 0, 0, 0, -1, 0, 0, 0, 0, 127};
        int exp_rnd [16] = '{1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int exp_sat [16] = '{127, -128, 127, -128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int t = 0; t < 4; t++) begin
            tbl[t] = '0;
            tbl[t].q[10] = 12'd1024;
            tbl[t].q[15] = 12'd1024;
        end
        tbl[0].q[0] = 12'd1024;  tbl[0].q[5] = 12'd1024;
        tbl[1].q[1] = 12'd1024;  tbl[1].q[4] = 12'd1024;
        tbl[2].q[0] = 12'd1024;  tbl[2].q[5] = 12'd1024;
        tbl[3].q[0] = 12'd1024;  tbl[3].q[5] = 12'd1024;
        for (int t = 0; t < 2; t++) begin
            tbl[t].r[0]  = 12'd80;
            tbl[t].r[1]  = 12'd8;
            tbl[t].r[2]  = 12'(-16);
            tbl[t].r[5]  = 12'd24;
            tbl[t].r[10] = 12'(-8);
            tbl[t].r[15] = 12'd1016;
        end
        tbl[2].r[0] = 12'd4;     tbl[2].r[1] = 12'(-4);
        tbl[2].r[2] = 12'(-5);   tbl[2].r[3] = 12'd3;
        tbl[3].r[0] = 12'd1200;  tbl[3].r[1] = 12'(-1200);
        tbl[3].r[2] = 12'd1016;  tbl[3].r[3] = 12'(-1024);
        for (int b = 0; b < 16; b++) begin
            tbl[0].exp[b] = 8'(exp_id[b]);
            tbl[1].exp[b] = 8'(exp_pm[b]);
            tbl[2].exp[b] = 8'(exp_rnd[b]);
            tbl[3].exp[b] = 8'(exp_sat[b]);
        end

        rst      = 1'b1;
        in_valid = 1'b0;
        in_q     = '0;
        in_r     = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", int'($signed(out)), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        rst = 1'b0;

        // Identity, permutation, rounding, saturation back to back from E83.
        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t], -1);
            check_frame(1'b0);
        end

        // Input gap after beat 5 plus ignored beats, then an immediate repeat.
        send_frame(tbl[0], 5);
        check_frame(1'b1);
        send_frame(tbl[0], -1);
        check_frame(1'b0);

        // Random frame against the arithmetic model.
        for (int b = 0; b < 16; b++) begin
            rv.q[b] = 12'($urandom_range(0, 2048) - 1024);
            rv.r[b] = 12'($urandom_range(0, 4095) - 2048);
        end
        rv.exp = model(rv);
        send_frame(rv, -1);
        check_frame(1'b0);

        // Reset sampled at E30 of CAL: no burst may follow.
        send_frame(tbl[0], -1);
        for (int d = 1; d <= 29; d++) begin
            @(negedge clk);
            chk("pre_reset_valid", int'(out_valid), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_out", int'($signed(out)), 0);
        chk("mid_reset_valid", int'(out_valid), 0);
        repeat (90) begin
            @(negedge clk);
            chk("no_burst_after_reset", int'(out_valid), 0);
        end
        sb.delete();
        send_frame(tbl[0], -1);
        check_frame(1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
